// File: rtl/ula_multiciclo_pkg.sv
// ula_pkg: shared definitions for the multi-cycle ALU.
//   - 4-bit operation codes (1100..1111 are unassigned)
//   - FSM state encoding (IDLE, RUN, DONE)
//   - is_multicycle(): ops that may iterate (shifts, MUL)
package ula_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_PASS = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_CMP  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  // Shifts only iterate when the shift amount is non-zero; MUL always does.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/ula_multiciclo_comb.sv
// ula_comb: combinational single-cycle ALU operations and their flags.
//   op    : operation code
//   a, b  : operands
//   res   : result (shift ops return a, i.e. the shift-by-zero result)
//   zero, carry, negative, overflow : flags for res
//   illegal : op code is unassigned (res and flags forced to 0)
module ula_comb
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] dif_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  // dif_ext[WIDTH] is the borrow, so its inverse means a >= b unsigned.
  assign dif_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    res      = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_ADD: begin
        res      = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_PASS: res = b;
      OP_SUB, OP_CMP: begin
        res      = dif_ext[WIDTH-1:0];
        carry    = ~dif_ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SLT: res[0] = ($signed(a) < $signed(b));
      OP_SLL, OP_SRL, OP_SRA: res = a;
      OP_MUL: res = '0;
      default: illegal = 1'b1;
    endcase
    zero     = ~illegal && (res == '0);
    negative = res[WIDTH-1];
  end

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: parametrised multi-cycle ALU with start/done handshake.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, ULAOp   : request and op code, accepted when ready=1
//   Dado1, Dado2   : operands A and B (shift amount = Dado2[SHW-1:0])
//   ready          : combinational, low only while iterating
//   busy           : registered, high while iterating
//   done           : one-cycle completion pulse
//   Resultado, zero, carry, negative, overflow, illegal : registered,
//                    updated only at completion
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ULAOp,
  input  logic [WIDTH-1:0] Dado1,
  input  logic [WIDTH-1:0] Dado2,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Resultado,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  state_t             state_q, state_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d, carry_q, carry_d, neg_q, neg_d;
  logic               ovf_q, ovf_d, ill_q, ill_d, done_q, done_d, busy_q, busy_d;

  logic [WIDTH-1:0]   c_res;
  logic               c_zero, c_carry, c_neg, c_ovf, c_ill;
  logic               accept;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   step_a;
  logic               step_c;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_prod;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c;

  ula_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (ULAOp),
    .a        (Dado1),
    .b        (Dado2),
    .res      (c_res),
    .zero     (c_zero),
    .carry    (c_carry),
    .negative (c_neg),
    .overflow (c_ovf),
    .illegal  (c_ill)
  );

  assign ready  = (state_q != ST_RUN);
  assign accept = start && ready;
  assign shamt  = Dado2[SHW-1:0];

  // One iteration: 1-bit shift of a_q, or one shift-add step of the
  // multiplier. prod_q holds {partial sum, remaining multiplier bits};
  // the addend is selected by the multiplier LSB and the whole thing
  // shifts right, so after WIDTH steps prod_q is the full product.
  always_comb begin
    step_a = a_q;
    step_c = 1'b0;
    case (op_q)
      OP_SLL: begin step_a = {a_q[WIDTH-2:0], 1'b0};     step_c = a_q[WIDTH-1]; end
      OP_SRL: begin step_a = {1'b0, a_q[WIDTH-1:1]};     step_c = a_q[0];       end
      OP_SRA: begin step_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; step_c = a_q[0];   end
      default: ;
    endcase
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    step_prod = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    prod_d  = prod_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    fin_res = '0;
    fin_c   = 1'b0;
    if (state_q == ST_RUN) begin
      a_d    = step_a;
      prod_d = step_prod;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == 'd1) begin
        if (op_q == OP_MUL) begin
          fin_res = step_prod[WIDTH-1:0];
          fin_c   = |step_prod[2*WIDTH-1:WIDTH];
        end else begin
          fin_res = step_a;
          fin_c   = step_c;
        end
        state_d = ST_DONE;
        done_d  = 1'b1;
        res_d   = fin_res;
        zero_d  = (fin_res == '0);
        carry_d = fin_c;
        neg_d   = fin_res[WIDTH-1];
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
      end
    end else begin
      state_d = ST_IDLE;
      if (accept) begin
        op_d   = ULAOp;
        a_d    = Dado1;
        prod_d = {{WIDTH{1'b0}}, Dado2};
        if (is_multicycle(ULAOp) && ((ULAOp == OP_MUL) || (shamt != '0))) begin
          state_d = ST_RUN;
          cnt_d   = (ULAOp == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, shamt};
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          res_d   = c_res;
          zero_d  = c_zero;
          carry_d = c_carry;
          neg_d   = c_neg;
          ovf_d   = c_ovf;
          ill_d   = c_ill;
        end
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Operand, op and product registers carry data only and are always
  // reloaded at accept, so they need no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    prod_q <= prod_d;
  end

  assign Resultado = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
module tb_ula_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] ULAOp;
  logic [7:0] Dado1, Dado2;
  logic       ready, busy, done;
  logic [7:0] Resultado;
  logic       zero, carry, negative, overflow, illegal;

  int n_vec = 0;
  int n_err = 0;

  ula_multiciclo #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ULAOp     (ULAOp),
    .Dado1     (Dado1),
    .Dado2     (Dado2),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .Resultado (Resultado),
    .zero      (zero),
    .carry     (carry),
    .negative  (negative),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // {zero, carry, negative, overflow, illegal}
  logic [4:0] flags;
  assign flags = {zero, carry, negative, overflow, illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request (called #1 after a rising edge), then wait for done.
  // lat = cycles from the accepting edge to the done cycle; bc = busy cycles.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bc);
    start = 1'b1; ULAOp = op; Dado1 = a; Dado2 = b;
    @(posedge clk); #1;
    start = 1'b0; Dado1 = 8'hA5; Dado2 = 8'h3C;
    lat = 1; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op_vec(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res,
                        input logic [4:0] exp_flags, input int exp_lat, input int exp_busy);
    int lat, bc;
    run_op(op, a, b, lat, bc);
    check_eq({tag, "_lat"},   lat,       exp_lat);
    check_eq({tag, "_res"},   Resultado, exp_res);
    check_eq({tag, "_flags"}, flags,     exp_flags);
    check_eq({tag, "_busy"},  bc,        exp_busy);
  endtask

  initial begin
    int ndone;
    logic [7:0] seen;
    rst_n = 1'b0; start = 1'b0; ULAOp = 4'h0; Dado1 = 8'h00; Dado2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_res",   Resultado, 8'h00);
    check_eq("rst_flags", flags,     5'b00000);
    check_eq("rst_ctl",   {done, busy, ready}, 3'b001);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //            tag      op     A      B      res    zcnvi     lat busy
    op_vec("add",  4'h0, 8'h7F, 8'h01, 8'h80, 5'b00110, 1, 0);
    op_vec("cmp",  4'h6, 8'h05, 8'h05, 8'h00, 5'b11000, 1, 0);
    op_vec("sub",  4'h2, 8'h80, 8'h01, 8'h7F, 5'b01010, 1, 0);
    op_vec("slt",  4'h7, 8'hFF, 8'h01, 8'h01, 5'b00000, 1, 0);
    op_vec("mul1", 4'hB, 8'h0D, 8'h14, 8'h04, 5'b01000, 9, 8);
    op_vec("mul2", 4'hB, 8'h0F, 8'h11, 8'hFF, 5'b00100, 9, 8);
    op_vec("sll",  4'h8, 8'h81, 8'h01, 8'h02, 5'b01000, 2, 1);
    op_vec("sra",  4'hA, 8'h80, 8'h07, 8'hFF, 5'b00100, 8, 7);
    op_vec("srl0", 4'h9, 8'h5A, 8'h08, 8'h5A, 5'b00000, 1, 0);
    op_vec("ill",  4'hE, 8'hFF, 8'h01, 8'h00, 5'b00001, 1, 0);
    op_vec("xor",  4'h5, 8'hF0, 8'h0F, 8'hFF, 5'b00100, 1, 0);

    // start pulse with ADD during MUL iteration must be ignored
    start = 1'b1; ULAOp = 4'hB; Dado1 = 8'h03; Dado2 = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; ULAOp = 4'h0; Dado1 = 8'h01; Dado2 = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; seen = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (done) begin ndone++; seen = Resultado; end
      @(posedge clk); #1;
    end
    check_eq("ign_ndone", ndone, 1);
    check_eq("ign_res",   seen,  8'h15);

    // back-to-back single-cycle ops
    start = 1'b1; ULAOp = 4'h0; Dado1 = 8'h01; Dado2 = 8'h02;
    @(posedge clk); #1;
    Dado1 = 8'h0A; Dado2 = 8'h14;
    check_eq("b2b_d1",  done,      1'b1);
    check_eq("b2b_r1",  Resultado, 8'h03);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_d2",  done,      1'b1);
    check_eq("b2b_r2",  Resultado, 8'h1E);
    @(posedge clk); #1;
    check_eq("b2b_d3",  done,      1'b0);

    // asynchronous reset in the 4th RUN cycle of MUL
    start = 1'b1; ULAOp = 4'hB; Dado1 = 8'h0D; Dado2 = 8'h14;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mrst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_res",   Resultado, 8'h00);
    check_eq("mrst_flags", flags,     5'b00000);
    check_eq("mrst_ctl",   {done, busy, ready}, 3'b001);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    op_vec("add23", 4'h0, 8'h02, 8'h03, 8'h05, 5'b00000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle ALU for the nRisc datapath. It succeeds the 8-bit single-cycle ALU. Word width is generic, the op set is extended with subtract, logic, compare, shifts and multiply, and status flags are registered. Simple ops complete in one cycle. Shifts and multiply iterate, and a start/done handshake lets the control unit stall the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width in bits (≥4, power of two).
- `SHW`, $clog2(WIDTH): shift-amount width (derived; not to be overridden).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: request; accepted when `ready`=1.
- `ULAOp`  in  4: operation code (see Operation).
- `Dado1`  in  WIDTH: operand A.
- `Dado2`  in  WIDTH: operand B (register or immediate, muxed upstream).
- `ready`  out  1: combinational, =1 when state ≠ RUN.
- `busy`  out  1: registered, =1 while state = RUN.
- `done`  out  1: registered one-cycle completion pulse.
- `Resultado`  out  WIDTH: registered result, held until the next completion.
- `zero`, `carry`, `negative`, `overflow`  out  1 each: registered flags, updated only at completion.
- `illegal`  out  1: registered; =1 when the last completed op was unassigned.

## Operation
- Op codes:
  - 0000 ADD: load, store, add and addi address/sum.
  - 0001 PASS B (LA).
  - 0010 SUB.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 CMP: result A−B; used for beq.
  - 0111 SLT, signed: result 1 or 0.
  - 1000 SLL.
  - 1001 SRL.
  - 1010 SRA.
  - 1011 MUL: low WIDTH bits of the product.
  - 1100–1111: illegal.
- Operands and op are captured at accept (`start` && `ready`). Input changes afterwards have no effect.
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
  - IDLE/DONE + accept of a single-cycle op or illegal op → DONE, with result and flags loaded.
  - IDLE/DONE + accept of a shift with shamt = `Dado2[SHW-1:0]` = 0 → DONE, result = A.
  - IDLE/DONE + accept of a shift with shamt > 0, or of MUL → RUN; counter loaded with shamt or WIDTH.
  - RUN: one step per cycle: 1-bit shift, or one shift-add iteration for MUL. The counter decrements each cycle; at 1 → DONE.
  - DONE without accept → IDLE.
- `start` while `busy` is ignored. It is neither queued nor acknowledged.
- Flags, computed on the final result:
  - `negative` = MSB of the result.
  - `zero` = (result == 0). For CMP this equals A==B.
  - `carry`:
    - ADD: carry-out.
    - SUB/CMP: 1 when A ≥ B unsigned.
    - Shifts: last bit shifted out; 0 if shamt = 0.
    - MUL: 1 when the upper WIDTH product bits are ≠ 0.
    - All other ops: 0.
  - `overflow`: signed overflow for ADD, SUB and CMP; 0 otherwise.
- Illegal op: result 0, all flags 0, `illegal`=1. `illegal` is cleared by the next legal completion.
- Arithmetic is modulo 2^WIDTH. MUL is unsigned and the product register is 2·WIDTH bits internally.

## Timing
- Reset (async, any state, including mid-RUN) clears outputs: `Resultado`=0, all flags 0, `illegal`=0, `done`=0, `busy`=0. State returns to IDLE, so `ready`=1. The partial product and counter are discarded.
- Latency is counted from the accepting edge to the cycle `done`=1:
  - Single-cycle ops: 1 cycle.
  - Shift by n>0: n+1 cycles.
  - MUL: WIDTH+1 cycles (9 for WIDTH=8).
- `done` is high for exactly one cycle. `Resultado` and the flags become valid in that same cycle and are held thereafter.
- Back-to-back: a `start` in the DONE cycle is accepted. Single-cycle ops therefore sustain one result per cycle.
- `busy` is high for exactly n (shift) or WIDTH (MUL) cycles.

## Structure
- Package `ula_pkg` holds:
  - the 4-bit op-code localparams/enum;
  - the FSM state enum;
  - helper function `is_multicycle(op)`.
- Sub-module `ula_comb` computes all single-cycle ops and their flags combinationally (WIDTH-parametrised).
- The top level holds the FSM, the operand, counter and product registers, the iterative shifter/multiplier and the output registers.

## Test plan
WIDTH=8 throughout.
- ADD 0x7F+0x01 → `Resultado`=0x80, `negative`=1, `overflow`=1, `carry`=0, `done` 1 cycle after accept. Repeat with CMP 0x05,0x05 → 0x00, `zero`=1, `carry`=1.
- MUL 0x0D×0x14 → 0x04, `carry`=1, `busy` high 8 cycles, `done` 9 cycles after accept. MUL 0x0F×0x11 → 0xFF, `carry`=0.
- SLL 0x81 by 1 → 0x02, `carry`=1, done at 2 cycles. SRA 0x80 by 7 → 0xFF. SRL by 0 → `Dado1` unchanged, done at 1 cycle, `carry`=0.
- Pulse `start` with ADD during MUL RUN → ignored: MUL result unaffected, exactly one `done`. Back-to-back ADDs on consecutive cycles → `done` on consecutive cycles with the correct results.
- Assert `rst_n`=0 in the 4th RUN cycle of MUL → all outputs 0 immediately, `ready`=1. A following ADD 2+3 → 0x05 in 1 cycle.
- Op 1110 with any operands → `Resultado`=0, `illegal`=1, flags 0. The next legal op clears `illegal`.
